apb_master: RTL and testbench

//  APB3 requester: turns single commands from a local valid/ready port into APB

---
 rtl/apb_master.sv | 149 ++++++++++++++
 tb/tb_apb_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB3 requester: converts single valid/ready commands into APB transfers with
// PREADY wait states, PSLVERR reporting and an optional bounded-wait timeout.
module apb_master #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  // Counter value at the start of the last permitted wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cmd_ready_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  // Next-state and next-output logic; every register holds unless overridden.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready comes up on the first edge after reset release.
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        if (cmd_valid && cmd_ready) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = ST_IDLE;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_ready   <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready   <= cmd_ready_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: the bench acts as command source and APB
// slave; a timeout-enabled and a timeout-disabled instance share the stimulus.
module tb_apb_master;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int          TMO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0, PSLVERR = 1'b0;

  logic          cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [AW-1:0] PADDR;

  logic          cmd_ready1, rsp_valid1, rsp_err1, rsp_timeout1, psel1, penable1, pwrite1;
  logic [DW-1:0] rsp_rdata1, pwdata1;
  logic [AW-1:0] paddr1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_notmo (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .rsp_timeout(rsp_timeout1),
    .PADDR(paddr1), .PSEL(psel1), .PENABLE(penable1), .PWRITE(pwrite1), .PWDATA(pwdata1),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            n_access;
  } exp_t;

  // Expected response from the transfer rules: slave inserts 'waits' low cycles.
  function automatic exp_t model(input bit wr, input int waits, input logic [DW-1:0] rd,
                                 input bit slverr);
    exp_t e;
    if (waits >= TMO) begin
      e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1; e.n_access = TMO;
    end else begin
      e.rdata = wr ? '0 : rd; e.err = slverr; e.tmo = 1'b0; e.n_access = waits + 1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 32'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE}), 32'd0);
    chk({tag, "_paddr"}, 32'(PADDR), 32'd0);
    chk({tag, "_pwdata"}, PWDATA, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_flags1"}, 32'({cmd_ready1, rsp_valid1, rsp_err1, rsp_timeout1, psel1, penable1, pwrite1}), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 40) begin
      @(negedge PCLK);
      guard++;
    end
    chk({tag, "_ready_wait"}, 32'(cmd_ready), 32'd1);
  endtask

  // One command end to end, checking the bus every cycle and the response.
  task automatic xfer(input string tag, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int waits,
                      input logic [DW-1:0] rd, input bit slverr);
    exp_t e;
    e = model(wr, waits, rd, slverr);
    wait_ready(tag);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
    @(negedge PCLK);
    chk({tag, "_setup_psel"}, 32'(PSEL), 32'd1);
    chk({tag, "_setup_pen"}, 32'(PENABLE), 32'd0);
    chk({tag, "_setup_rdy"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_setup_addr"}, 32'(PADDR), 32'(a));
    chk({tag, "_setup_wr"}, 32'(PWRITE), 32'(wr));
    chk({tag, "_setup_wd"}, PWDATA, wd);
    // Busy: command lines carry junk that must be ignored.
    cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
    PREADY = 1'($urandom);
    for (int k = 0; k < e.n_access; k++) begin
      @(negedge PCLK);
      chk({tag, "_acc_sel"}, 32'({PSEL, PENABLE}), 32'd3);
      chk({tag, "_acc_addr"}, 32'(PADDR), 32'(a));
      chk({tag, "_acc_wr"}, 32'(PWRITE), 32'(wr));
      chk({tag, "_acc_wd"}, PWDATA, wd);
      chk({tag, "_acc_rsp"}, 32'({rsp_valid, cmd_ready}), 32'd0);
      PREADY  = (k == waits);
      PRDATA  = (k == waits) ? rd : $urandom;
      PSLVERR = (k == waits) ? slverr : 1'($urandom);
    end
    @(negedge PCLK);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(e.err));
    chk({tag, "_rsp_tmo"}, 32'(rsp_timeout), 32'(e.tmo));
    chk({tag, "_rsp_bus"}, 32'({PSEL, PENABLE}), 32'd0);
    chk({tag, "_rsp_rdy"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0; PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
    @(negedge PCLK);
    chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_hold_flags"}, 32'({rsp_err, rsp_timeout}), 32'({e.err, e.tmo}));
  endtask

  initial begin
    int waits, r;
    int pulses;

    // Reset state
    repeat (2) @(negedge PCLK);
    chk_zero("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("release_ready", 32'(cmd_ready), 32'd1);
    chk("release_bus", 32'({PSEL, PENABLE, rsp_valid}), 32'd0);

    // Directed transfers
    xfer("wr_basic", 1'b1, 8'h00, 32'h0000A5A5, 0, $urandom, 1'b0);
    xfer("rd_basic", 1'b0, 8'h04, $urandom, 0, 32'h00001234, 1'b0);
    xfer("rd_wait3", 1'b0, 8'h08, $urandom, 3, 32'h89ABCDEF, 1'b0);
    xfer("wr_slverr", 1'b1, 8'h0C, 32'h11223344, 0, $urandom, 1'b1);
    xfer("rd_after_err", 1'b0, 8'h10, $urandom, 1, 32'h55AA55AA, 1'b0);
    xfer("rd_wait15", 1'b0, 8'h14, $urandom, TMO - 1, 32'hFEEDF00D, 1'b0);
    xfer("rd_wait16", 1'b0, 8'h18, $urandom, TMO, 32'hDEADBEEF, 1'b0);

    // Randomized transfers
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 9));
      waits = (r < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(TMO - 2, TMO + 1));
      xfer("rand", 1'($urandom), 8'($urandom), $urandom, waits, $urandom, 1'($urandom));
    end

    // Fresh reset so both instances start aligned
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk_zero("reset2");
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Stuck PREADY: timeout instance aborts, disabled instance keeps waiting
    xfer("stuck", 1'b0, 8'h20, 32'h0, TMO + 8, 32'h12345678, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      chk("notmo_waiting", 32'({psel1, penable1, rsp_valid1, cmd_ready1}), 32'b1100);
    end

    // Reset in the middle of ACCESS
    wait_ready("midrst");
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h24; cmd_wdata = 32'hCAFEBABE;
    PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("midrst_access", 32'({PSEL, PENABLE, psel1, penable1}), 32'hF);
    #2 PRESETn = 1'b0;
    #1;
    chk_zero("midrst");
    PREADY = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      chk("midrst_norsp", 32'({rsp_valid, rsp_valid1, PSEL, psel1}), 32'd0);
    end
    chk("midrst_ready", 32'({cmd_ready, cmd_ready1}), 32'd3);

    // Back-to-back: cmd_valid held high, one transfer every 3 cycles
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hB2B2B2B2;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge PCLK);
      chk("b2b_psel", 32'(PSEL), 32'((i % 3) != 2));
      chk("b2b_rsp", 32'(rsp_valid), 32'((i % 3) == 2));
      if (rsp_valid === 1'b1) begin
        pulses++;
        chk("b2b_rdata", rsp_rdata, 32'hB2B2B2B2);
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd4);
    @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
